// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: alternating-priority grant of one transaction at a time
// to a registered-output RAM, plus a memory-mapped LED register and switch input.
module mem_arb_port (
  input  logic       req,
  input  logic [1:0] cmd,
  output logic       active
);
  // Only MREAD (1) and MWRITE (2) count as real requests.
  assign active = req && (cmd == 2'd1 || cmd == 2'd2);
endmodule

module mem_arbiter #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  cmd0,
  input  logic [1:0]  cmd1,
  input  logic [8:0]  addr0,
  input  logic [8:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic [7:0]  ram_addr,
  output logic        ram_write,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  sw,
  output logic [7:0]  led
);
  localparam int NUM_PORTS = 2;
  localparam logic [1:0] MWRITE = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
  } xact_t;

  state_t state, state_nxt;
  xact_t  cur;
  logic [NUM_PORTS-1:0]       req_a, active, gnt, done;
  logic [NUM_PORTS-1:0][1:0]  cmd_a;
  logic [NUM_PORTS-1:0][8:0]  addr_a;
  logic [NUM_PORTS-1:0][15:0] wdata_a;
  logic take, pick, owner, last;
  logic is_wr, led_ld, fin;
  logic [15:0] rd_val;

  assign req_a   = {req1, req0};
  assign cmd_a   = {cmd1, cmd0};
  assign addr_a  = {addr1, addr0};
  assign wdata_a = {wdata1, wdata0};

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      mem_arb_port u_port (
        .req    (req_a[p]),
        .cmd    (cmd_a[p]),
        .active (active[p])
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    unique case (state)
      IDLE: if (|active) begin
        take      = 1'b1;
        // On contention the port not served last wins.
        pick      = (&active) ? ~last : active[1];
        state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = (cur.cmd == MWRITE) ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ram_write is decoded from state so an async reset removes it immediately.
  assign is_wr     = (state == ACCESS) && (cur.cmd == MWRITE);
  assign ram_write = is_wr && !cur.addr[8];
  assign led_ld    = is_wr && (cur.addr == LED_ADDR);
  assign fin       = is_wr || (state == RDWAIT);
  assign ram_addr  = cur.addr[7:0];
  assign ram_din   = cur.wdata;

  always_comb begin
    rd_val = 16'h0000;
    if (!cur.addr[8])           rd_val = ram_dout;
    else if (cur.addr == SW_ADDR) rd_val = {8'h00, sw};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cur   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
      gnt   <= '0;
      done  <= '0;
      rdata <= 16'h0000;
      led   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (take) begin
        cur   <= '{cmd: cmd_a[pick], addr: addr_a[pick], wdata: wdata_a[pick]};
        owner <= pick;
        last  <= pick;
      end
      gnt  <= take ? (pick ? 2'b10 : 2'b01) : 2'b00;
      done <= fin ? (owner ? 2'b10 : 2'b01) : 2'b00;
      if (state == RDWAIT) rdata <= rd_val;
      if (led_ld)          led   <= cur.wdata[7:0];
    end
  end

  assign gnt0  = gnt[0];
  assign gnt1  = gnt[1];
  assign done0 = done[0];
  assign done1 = done[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  led;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout), .sw(sw), .led(led)
  );

  initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; cmd0 = 2'd3; cmd1 = 2'd3;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic test_reset();
    reset = 0; idle_inputs(); sw = 8'h00;
    req0 = 1; cmd0 = 2'd2; addr0 = 9'h011; wdata0 = 16'h5555;
    tick(); tick();
    total++; if ({gnt0, gnt1, done0, done1, ram_write} !== 5'b0) $display("FAIL rst_ctrl got %b want 00000", {gnt0, gnt1, done0, done1, ram_write}); else passed++;
    total++; if (ram_addr !== 8'h00) $display("FAIL rst_ram_addr got %h want 00", ram_addr); else passed++;
    total++; if (ram_din !== 16'h0000) $display("FAIL rst_ram_din got %h want 0000", ram_din); else passed++;
    total++; if (rdata !== 16'h0000) $display("FAIL rst_rdata got %h want 0000", rdata); else passed++;
    total++; if (led !== 8'h00) $display("FAIL rst_led got %h want 00", led); else passed++;
    idle_inputs();
    reset = 1;
    tick();
  endtask

  task automatic test_alternate();
    int ng, dones, ovl, bad;
    logic [3:0] ord;
    logic own;
    ng = 0; dones = 0; ovl = 0; bad = 0; ord = '0; own = 0;
    req0 = 1; cmd0 = 2'd1; addr0 = 9'h003;
    req1 = 1; cmd1 = 2'd1; addr1 = 9'h004;
    for (int c = 0; c < 40 && dones < 4; c++) begin
      tick();
      if (gnt0 && gnt1) ovl++;
      if (done0 && done1) ovl++;
      if (gnt0 || gnt1) begin
        own = gnt1;
        if (ng < 4) ord[ng] = gnt1;
        ng++;
        if (ng == 4) begin req0 = 0; req1 = 0; end
      end
      if (done0 || done1) begin
        dones++;
        if (done1 !== own) bad++;
        if (rdata !== (own ? 16'hA004 : 16'hA003)) bad++;
      end
    end
    total++; if (ng !== 4) $display("FAIL alt_grants got %0d want 4", ng); else passed++;
    total++; if (dones !== 4) $display("FAIL alt_dones got %0d want 4", dones); else passed++;
    total++; if (ord !== 4'b1010) $display("FAIL alt_order got %b want 1010", ord); else passed++;
    total++; if (ovl !== 0) $display("FAIL alt_overlap got %0d want 0", ovl); else passed++;
    total++; if (bad !== 0) $display("FAIL alt_owner_data got %0d want 0", bad); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1; cmd0 = 2'd2; addr0 = 9'h005; wdata0 = 16'hBEEF;
    tick();
    req0 = 0;
    total++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL wr_gnt got %b want 10", {gnt0, gnt1}); else passed++;
    total++; if (ram_write !== 1'b1 || ram_addr !== 8'h05 || ram_din !== 16'hBEEF) $display("FAIL wr_ram got %b/%h/%h want 1/05/beef", ram_write, ram_addr, ram_din); else passed++;
    tick();
    total++; if ({done0, gnt0, ram_write} !== 3'b100) $display("FAIL wr_done got %b want 100", {done0, gnt0, ram_write}); else passed++;
    tick();
    total++; if (done0 !== 1'b0) $display("FAIL wr_done_pulse got %b want 0", done0); else passed++;
    req0 = 1; cmd0 = 2'd1;
    tick();
    req0 = 0;
    total++; if (gnt0 !== 1'b1) $display("FAIL rd_gnt got %b want 1", gnt0); else passed++;
    tick();
    total++; if ({gnt0, done0} !== 2'b00) $display("FAIL rd_wait got %b want 00", {gnt0, done0}); else passed++;
    tick();
    total++; if (done0 !== 1'b1 || rdata !== 16'hBEEF) $display("FAIL rd_done got %b/%h want 1/beef", done0, rdata); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_led();
    req1 = 1; cmd1 = 2'd2; addr1 = 9'h100; wdata1 = 16'h00A5;
    tick();
    req1 = 0;
    total++; if (gnt1 !== 1'b1 || ram_write !== 1'b0) $display("FAIL led_gnt got %b/%b want 1/0", gnt1, ram_write); else passed++;
    tick();
    total++; if (done1 !== 1'b1 || led !== 8'hA5) $display("FAIL led_load got %b/%h want 1/a5", done1, led); else passed++;
    tick();
    req1 = 1; addr1 = 9'h180; wdata1 = 16'h1234;
    tick();
    req1 = 0;
    total++; if (gnt1 !== 1'b1 || ram_write !== 1'b0) $display("FAIL hole_gnt got %b/%b want 1/0", gnt1, ram_write); else passed++;
    tick();
    total++; if (done1 !== 1'b1 || led !== 8'hA5) $display("FAIL hole_done got %b/%h want 1/a5", done1, led); else passed++;
    total++; if (mem[8'h80] !== 16'hA080) $display("FAIL hole_ram got %h want a080", mem[8'h80]); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_sw();
    sw = 8'h3C;
    req0 = 1; cmd0 = 2'd1; addr0 = 9'h140;
    tick(); req0 = 0; tick(); tick();
    total++; if (done0 !== 1'b1 || rdata !== 16'h003C) $display("FAIL sw_read got %b/%h want 1/003c", done0, rdata); else passed++;
    tick();
    req0 = 1; cmd0 = 2'd2; addr0 = 9'h010; wdata0 = 16'h7777;
    tick(); req0 = 0; tick();
    total++; if (done0 !== 1'b1 || rdata !== 16'h003C) $display("FAIL rdata_hold got %b/%h want 1/003c", done0, rdata); else passed++;
    tick();
    req0 = 1; cmd0 = 2'd1; addr0 = 9'h1FF;
    tick(); req0 = 0; tick(); tick();
    total++; if (done0 !== 1'b1 || rdata !== 16'h0000) $display("FAIL hole_read got %b/%h want 1/0000", done0, rdata); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_abort();
    req0 = 1; cmd0 = 2'd2; addr0 = 9'h020; wdata0 = 16'hCAFE;
    tick();
    req0 = 0;
    total++; if (ram_write !== 1'b1) $display("FAIL abort_pre got %b want 1", ram_write); else passed++;
    #2 reset = 0;
    #1;
    total++; if (ram_write !== 1'b0) $display("FAIL abort_async got %b want 0", ram_write); else passed++;
    tick();
    total++; if ({done0, done1, gnt0, gnt1} !== 4'b0) $display("FAIL abort_done got %b want 0000", {done0, done1, gnt0, gnt1}); else passed++;
    total++; if (led !== 8'h00) $display("FAIL abort_led got %h want 00", led); else passed++;
    total++; if (mem[8'h20] !== 16'hA020) $display("FAIL abort_ram got %h want a020", mem[8'h20]); else passed++;
    reset = 1;
    req0 = 1; cmd0 = 2'd1; addr0 = 9'h001;
    req1 = 1; cmd1 = 2'd1; addr1 = 9'h002;
    tick();
    idle_inputs();
    total++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL abort_prio got %b want 10", {gnt0, gnt1}); else passed++;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_write_read();
    test_led();
    test_sw();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LED_ADDR, default 9'h100, the LED register address.
REQ-002 The block SHALL have parameter SW_ADDR, default 9'h140, the switch read address.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset; clears all state when 0, independent of clk.
REQ-005 The block SHALL have ports req0/req1  input  1 each  requester 0 (CPU) / requester 1 (DMA/debug) request.
REQ-006 The block SHALL have ports cmd0/cmd1  input  2 each  1=MREAD, 2=MWRITE, 3=MNONE; 0 and 3 are no-op.
REQ-007 The block SHALL have ports addr0/addr1  input  9 each, and wdata0/wdata1  input  16 each.
REQ-008 The block SHALL have ports gnt0/gnt1  output  1 each  request-accepted pulse.
REQ-009 The block SHALL have ports done0/done1  output  1 each  transaction-complete pulse.
REQ-010 The block SHALL have port rdata  output  16  read result, valid while done0 or done1 is high after a read.
REQ-011 The block SHALL have ports ram_addr  output  8,  ram_write  output  1,  and ram_din  output  16, which drive the RAM.
REQ-012 The block SHALL have port ram_dout  input  16  RAM read data, registered in the RAM, one-cycle latency.
REQ-013 The block SHALL have port sw  input  8  switch inputs.
REQ-014 The block SHALL have port led  output  8  LED register.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RDWAIT.
REQ-016 A port SHALL be requesting when its req=1 and its cmd is 1 or 2; otherwise it SHALL be ignored.
REQ-017 In IDLE, on an edge with at least one port requesting, the FSM SHALL select a port, latch its cmd, addr and wdata, assert that port's gnt for exactly the following cycle, and enter ACCESS.
REQ-018 When both ports request, the port not served last SHALL win; after reset, port 0 SHALL have priority.
REQ-019 In ACCESS, ram_addr SHALL equal latched addr[7:0] and ram_din SHALL equal latched wdata; ram_addr SHALL hold the latched address in every state.
REQ-020 ram_write SHALL be 1 only in ACCESS with latched cmd=MWRITE and addr[8]=0; it SHALL be decoded combinationally from state and SHALL be 0 in every other case.
REQ-021 In ACCESS with cmd=MWRITE and addr=LED_ADDR, led SHALL load wdata[7:0] at the edge leaving ACCESS.
REQ-022 A write to any other address with addr[8]=1 SHALL have no effect but SHALL still complete.
REQ-023 On a write, leaving ACCESS SHALL go to IDLE and assert the owner's done for one cycle: done SHALL go high one cycle after gnt.
REQ-024 On a read, leaving ACCESS SHALL go to RDWAIT.
REQ-025 In RDWAIT, rdata SHALL be registered at the edge leaving RDWAIT as follows: ram_dout if addr[8]=0; {8'h00, sw} if addr=SW_ADDR; 16'h0000 otherwise.
REQ-026 After a read, the FSM SHALL return to IDLE and assert the owner's done for one cycle: done SHALL go high two cycles after gnt.
REQ-027 rdata SHALL hold its value until the next read completes.
REQ-028 req and cmd SHALL be sampled only in IDLE; changes during ACCESS or RDWAIT SHALL be ignored.
REQ-029 A requester that still holds req after its done SHALL be re-arbitrated, and the other port SHALL win if it is requesting.
REQ-030 At most one gnt and at most one done SHALL be high in any cycle.
REQ-031 There SHALL be at least one IDLE cycle between transactions.

Reset
REQ-032 While reset=0, the block SHALL hold state=IDLE; gnt0, gnt1, done0, done1, ram_write = 0; ram_addr = 8'h00; ram_din, rdata = 16'h0000; led = 8'h00; priority = port 0.
REQ-033 Reset asserted in ACCESS or RDWAIT SHALL abort the transaction immediately: ram_write SHALL drop asynchronously, no done SHALL be issued, and led SHALL not update.
REQ-034 The first edge after reset is released SHALL be treated as IDLE arbitration.

Verification
REQ-035 Port 0 writes 16'hBEEF to addr 9'h005 -> gnt0 for 1 cycle, ram_write=1 with ram_addr=8'h05 the next cycle, done0 one cycle after gnt0; a following read of 9'h005 returns rdata=16'hBEEF with done0 two cycles after gnt0.
REQ-036 Both ports request reads in the same IDLE cycle and hold req -> grant order 0,1,0,1; gnt never overlaps; each done matches its owner.
REQ-037 Port 1 writes 16'h00A5 to 9'h100 -> led=8'hA5 and ram_write stays 0; a write of 16'h1234 to 9'h180 -> no change to led or RAM, done1 still pulses.
REQ-038 sw=8'h3C, port 0 reads 9'h140 -> rdata=16'h003C; a read of 9'h1FF -> rdata=16'h0000.
REQ-039 Reset asserted mid-ACCESS of a write -> ram_write falls with reset, no done; after release, led=8'h00 and a port 0 + port 1 request grants port 0 first.
